acc_stack_register: RTL and testbench

ACC_STACK_REGISTER -- requirements
Module: acc_stack_register

---
 rtl/acc_pkg.sv | 19 +
 rtl/acc_lifo.sv | 78 +++++++
 rtl/acc_stack_register.sv | 125 ++++++++++++
 tb/tb_acc_stack_register.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator/stack register: operation encoding
// and the op-select width.
package acc_pkg;

  localparam int unsigned OP_W = 3;

  // Accumulator operation select
  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_INC  = 3'b101,
    OP_DEC  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

endpackage : acc_pkg

// File: rtl/acc_lifo.sv
// LIFO save-stack for the accumulator.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (clears count only)
//   push_i, pop_i   : push alone, pop alone, or both together (swap with top)
//   din_i           : value written on push or swap
//   top_o           : current top entry (0 when empty)
//   full_o, empty_o : occupancy flags derived from the registered count
module acc_lifo
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    wr_idx;
  logic             wr_en;
  logic             do_push, do_pop, do_swap;

  assign empty_o = (count_q == CW'(0));
  assign full_o  = (count_q == CW'(DEPTH));

  // Top index is only meaningful when the stack is not empty
  assign top_idx = IW'(count_q - CW'(1));
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  // Blocked operations (push when full, pop when empty) leave the stack alone
  assign do_swap = push_i &  pop_i & ~empty_o;
  assign do_pop  = ~push_i & pop_i & ~empty_o;
  assign do_push = push_i & ~pop_i & ~full_o;

  // Next count and write port selection
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = top_idx;
    if (do_push) begin
      count_d = count_q + CW'(1);
      wr_en   = 1'b1;
      wr_idx  = IW'(count_q);
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
    end else if (do_swap) begin
      wr_en   = 1'b1;
    end
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset; entries above count are unreachable
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= din_i;
    end
  end

endmodule : acc_lifo

// File: rtl/acc_stack_register.sv
// Accumulator register with shift/rotate/inc/dec datapath, carry and sticky
// error flags, a tri-state bus port and a LIFO save-stack.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   enable          : 1 drives the accumulator onto w_bus, 0 releases it
//   load            : active-low load of the accumulator from w_bus
//   op              : accumulator operation (acc_pkg::op_t encoding)
//   push, pop       : save to / restore from the stack (both = swap)
//   alu_connection  : accumulator value
//   w_bus           : shared bidirectional bus
//   zero, carry, full, empty, err : status flags
module acc_stack_register
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [OP_W-1:0]  op,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] alu_connection,
  inout  wire  [WIDTH-1:0] w_bus,
  output logic             zero,
  output logic             carry,
  output logic             full,
  output logic             empty,
  output logic             err
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] lifo_top;
  logic [WIDTH-1:0] load_val;

  acc_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (acc_q),
    .top_o   (lifo_top),
    .full_o  (full),
    .empty_o (empty)
  );

  // Bus tri-state driver
  assign w_bus = enable ? acc_q : {WIDTH{1'bz}};

  // While driving the bus ourselves, a load simply reloads our own value
  assign load_val = enable ? acc_q : w_bus;

  assign alu_connection = acc_q;
  assign carry          = carry_q;
  assign err            = err_q;
  assign zero           = (acc_q == '0);

  // Accumulator source select: successful pop > load > op
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    err_d   = err_q;
    if ((push && !pop && full) || (pop && empty)) begin
      err_d = 1'b1;
    end
    if (pop && !empty) begin
      acc_d = lifo_top;
    end else if (!load) begin
      acc_d = load_val;
    end else begin
      case (op_t'(op))
        OP_HOLD: ;
        OP_SHL: begin
          acc_d   = {acc_q[WIDTH-2:0], 1'b0};
          carry_d = acc_q[WIDTH-1];
        end
        OP_SHR: begin
          acc_d   = {1'b0, acc_q[WIDTH-1:1]};
          carry_d = acc_q[0];
        end
        OP_ROL: begin
          acc_d   = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
          carry_d = acc_q[WIDTH-1];
        end
        OP_ROR: begin
          acc_d   = {acc_q[0], acc_q[WIDTH-1:1]};
          carry_d = acc_q[0];
        end
        OP_INC: begin
          acc_d   = acc_q + WIDTH'(1);
          carry_d = &acc_q;
        end
        OP_DEC: begin
          acc_d   = acc_q - WIDTH'(1);
          carry_d = ~|acc_q;
        end
        OP_CLR: begin
          acc_d   = '0;
        end
        default: ;
      endcase
    end
  end

  // Accumulator and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

endmodule : acc_stack_register

// File: tb/tb_acc_stack_register.sv
// Directed bench for acc_stack_register (WIDTH=8, DEPTH=4).
module tb_acc_stack_register;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [2:0] op;
  logic       push;
  logic       pop;
  logic [7:0] alu_connection;
  wire  [7:0] w_bus;
  logic       zero, carry, full, empty, err;

  logic       tb_en;
  logic [7:0] tb_data;

  int n_asserts = 0;
  int n_fail    = 0;

  assign w_bus = tb_en ? tb_data : 8'bz;

  always #5 clk = ~clk;

  acc_stack_register #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .load           (load),
    .op             (op),
    .push           (push),
    .pop            (pop),
    .alu_connection (alu_connection),
    .w_bus          (w_bus),
    .zero           (zero),
    .carry          (carry),
    .full           (full),
    .empty          (empty),
    .err            (err)
  );

  typedef struct {
    logic       en;
    logic       ld_n;
    logic [2:0] op;
    logic       push;
    logic       pop;
    logic [7:0] bus;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       full;
    logic       empty;
    logic       err;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check state just after the rising edge
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    enable  = v.en;
    load    = v.ld_n;
    op      = v.op;
    push    = v.push;
    pop     = v.pop;
    tb_data = v.bus;
    tb_en   = ~v.en;
    @(posedge clk);
    #1;
    chk({tag, ".acc"},   32'(alu_connection), 32'(v.acc));
    chk({tag, ".carry"}, 32'(carry),          32'(v.c));
    chk({tag, ".zero"},  32'(zero),           32'(v.z));
    chk({tag, ".full"},  32'(full),           32'(v.full));
    chk({tag, ".empty"}, 32'(empty),          32'(v.empty));
    chk({tag, ".err"},   32'(err),            32'(v.err));
    if (v.en) chk({tag, ".bus"}, 32'(w_bus), 32'(v.acc));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".acc"},   32'(alu_connection), 32'h0);
    chk({tag, ".zero"},  32'(zero),           32'h1);
    chk({tag, ".empty"}, 32'(empty),          32'h1);
    chk({tag, ".full"},  32'(full),           32'h0);
    chk({tag, ".carry"}, 32'(carry),          32'h0);
    chk({tag, ".err"},   32'(err),            32'h0);
  endtask

  initial begin
    //          en  ld  op       pu  po  bus    acc    c   z   f   e   err
    tbl[0]  = '{1'b0,1'b0,OP_HOLD,1'b0,1'b0,8'hA5, 8'hA5,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[1]  = '{1'b1,1'b1,OP_HOLD,1'b0,1'b0,8'h00, 8'hA5,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[2]  = '{1'b1,1'b0,OP_HOLD,1'b0,1'b0,8'h00, 8'hA5,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[3]  = '{1'b0,1'b0,OP_HOLD,1'b0,1'b0,8'h81, 8'h81,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[4]  = '{1'b0,1'b1,OP_SHL, 1'b0,1'b0,8'h00, 8'h02,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[5]  = '{1'b0,1'b0,OP_SHL, 1'b0,1'b0,8'h81, 8'h81,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[6]  = '{1'b0,1'b1,OP_ROR, 1'b0,1'b0,8'h00, 8'hC0,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[7]  = '{1'b0,1'b1,OP_SHR, 1'b0,1'b0,8'h00, 8'h60,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b1,OP_ROL, 1'b0,1'b0,8'h00, 8'hC0,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[9]  = '{1'b0,1'b0,OP_HOLD,1'b0,1'b0,8'hFF, 8'hFF,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[10] = '{1'b0,1'b1,OP_INC, 1'b0,1'b0,8'h00, 8'h00,1'b1,1'b1,1'b0,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b1,OP_CLR, 1'b0,1'b0,8'h00, 8'h00,1'b1,1'b1,1'b0,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b1,OP_DEC, 1'b0,1'b0,8'h00, 8'hFF,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[13] = '{1'b0,1'b1,OP_DEC, 1'b0,1'b0,8'h00, 8'hFE,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[14] = '{1'b1,1'b1,OP_HOLD,1'b0,1'b0,8'h00, 8'hFE,1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[15] = '{1'b0,1'b1,OP_ROL, 1'b0,1'b0,8'h00, 8'hFD,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b1,OP_ROR, 1'b0,1'b0,8'h00, 8'hFE,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[17] = '{1'b0,1'b1,OP_SHR, 1'b0,1'b0,8'h00, 8'h7F,1'b0,1'b0,1'b0,1'b1,1'b0};

    reset = 1'b0; enable = 1'b0; load = 1'b1; op = OP_HOLD;
    push = 1'b0; pop = 1'b0; tb_en = 1'b0; tb_data = 8'h00;
    #12;
    chk_reset("por");
    @(negedge clk);
    reset = 1'b1;

    // Single-cycle datapath vectors
    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Fill the stack, overflow, then drain (a load during pop is ignored)
    apply('{1'b0,1'b0,OP_HOLD,1'b0,1'b0,8'h11, 8'h11,1'b0,1'b0,1'b0,1'b1,1'b0}, "ld11");
    apply('{1'b0,1'b0,OP_HOLD,1'b1,1'b0,8'h22, 8'h22,1'b0,1'b0,1'b0,1'b0,1'b0}, "push1");
    apply('{1'b0,1'b0,OP_HOLD,1'b1,1'b0,8'h33, 8'h33,1'b0,1'b0,1'b0,1'b0,1'b0}, "push2");
    apply('{1'b0,1'b0,OP_HOLD,1'b1,1'b0,8'h44, 8'h44,1'b0,1'b0,1'b0,1'b0,1'b0}, "push3");
    apply('{1'b0,1'b0,OP_HOLD,1'b1,1'b0,8'h55, 8'h55,1'b0,1'b0,1'b1,1'b0,1'b0}, "push4");
    apply('{1'b0,1'b1,OP_HOLD,1'b1,1'b0,8'h00, 8'h55,1'b0,1'b0,1'b1,1'b0,1'b1}, "push5");
    apply('{1'b0,1'b0,OP_INC, 1'b0,1'b1,8'hEE, 8'h44,1'b0,1'b0,1'b0,1'b0,1'b1}, "pop1");
    apply('{1'b0,1'b1,OP_CLR, 1'b0,1'b1,8'h00, 8'h33,1'b0,1'b0,1'b0,1'b0,1'b1}, "pop2");
    apply('{1'b0,1'b1,OP_HOLD,1'b0,1'b1,8'h00, 8'h22,1'b0,1'b0,1'b0,1'b0,1'b1}, "pop3");
    apply('{1'b0,1'b1,OP_HOLD,1'b0,1'b1,8'h00, 8'h11,1'b0,1'b0,1'b0,1'b1,1'b1}, "pop4");

    // Asynchronous reset between edges with acc=0x3C, count=2, err=1
    apply('{1'b0,1'b0,OP_HOLD,1'b1,1'b0,8'h3C, 8'h3C,1'b0,1'b0,1'b0,1'b0,1'b1}, "pre_a");
    apply('{1'b0,1'b1,OP_HOLD,1'b1,1'b0,8'h00, 8'h3C,1'b0,1'b0,1'b0,1'b0,1'b1}, "pre_b");
    @(negedge clk);
    push = 1'b0; pop = 1'b0; load = 1'b1; op = OP_HOLD; tb_en = 1'b0; enable = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_reset("mid_rst");
    chk("mid_rst.bus", 32'(w_bus), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    apply('{1'b0,1'b0,OP_HOLD,1'b0,1'b0,8'h5A, 8'h5A,1'b0,1'b0,1'b0,1'b1,1'b0}, "post_rst");

    // Pop on empty stack: op still applies, err sets
    apply('{1'b0,1'b0,OP_HOLD,1'b0,1'b0,8'h05, 8'h05,1'b0,1'b0,1'b0,1'b1,1'b0}, "ld05");
    apply('{1'b0,1'b1,OP_INC, 1'b0,1'b1,8'h00, 8'h06,1'b0,1'b0,1'b0,1'b1,1'b1}, "pop_empty");

    // Swap: acc=0x07, top=0x09
    apply('{1'b0,1'b0,OP_HOLD,1'b0,1'b0,8'h09, 8'h09,1'b0,1'b0,1'b0,1'b1,1'b1}, "ld09");
    apply('{1'b0,1'b0,OP_HOLD,1'b1,1'b0,8'h07, 8'h07,1'b0,1'b0,1'b0,1'b0,1'b1}, "push09");
    apply('{1'b0,1'b1,OP_HOLD,1'b1,1'b1,8'h00, 8'h09,1'b0,1'b0,1'b0,1'b0,1'b1}, "swap");
    apply('{1'b0,1'b1,OP_HOLD,1'b0,1'b1,8'h00, 8'h07,1'b0,1'b0,1'b0,1'b1,1'b1}, "pop_swap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_acc_stack_register
